// File: rtl/apb_master_if.sv
// Command, response and APB bus signals of the single-outstanding APB initiator.
// The master modport is the initiator's view; slave is the command source/responder side.
interface apb_master_if;
  logic        I_CMD_VALID;
  logic        O_CMD_READY;
  logic        I_CMD_WRITE;
  logic [31:0] I_CMD_ADDR;
  logic [31:0] I_CMD_WDATA;
  logic        O_RSP_VALID;
  logic        I_RSP_READY;
  logic [31:0] O_RSP_RDATA;
  logic        O_RSP_ERR;
  logic        O_PSEL;
  logic        O_PENABLE;
  logic        O_PWRITE;
  logic [31:0] O_PADDR;
  logic [31:0] O_PWDATA;
  logic [31:0] I_PRDATA;
  logic        I_PREADY;

  modport master (
    input  I_CMD_VALID, I_CMD_WRITE, I_CMD_ADDR, I_CMD_WDATA, I_RSP_READY, I_PRDATA, I_PREADY,
    output O_CMD_READY, O_RSP_VALID, O_RSP_RDATA, O_RSP_ERR,
    output O_PSEL, O_PENABLE, O_PWRITE, O_PADDR, O_PWDATA
  );

  modport slave (
    output I_CMD_VALID, I_CMD_WRITE, I_CMD_ADDR, I_CMD_WDATA, I_RSP_READY, I_PRDATA, I_PREADY,
    input  O_CMD_READY, O_RSP_VALID, O_RSP_RDATA, O_RSP_ERR,
    input  O_PSEL, O_PENABLE, O_PWRITE, O_PADDR, O_PWDATA
  );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB initiator: valid/ready command in, SETUP/ACCESS on APB,
// one response out with backpressure; ACCESS wait states abort after TIMEOUT cycles.
module apb_master #(
  parameter int unsigned TIMEOUT = 16
) (
  input logic          I_PCLK,
  input logic          I_PRESET_N,
  apb_master_if.master bus
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  // Abort when the wait counter would reach TIMEOUT with PREADY still low.
  localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

  state_e     state_q;
  logic [7:0] wait_q;

  assign bus.O_CMD_READY = (state_q == StIdle);

  always_ff @(posedge I_PCLK) begin
    if (!I_PRESET_N) begin
      state_q         <= StIdle;
      wait_q          <= '0;
      bus.O_PSEL      <= 1'b0;
      bus.O_PENABLE   <= 1'b0;
      bus.O_PWRITE    <= 1'b0;
      bus.O_PADDR     <= '0;
      bus.O_PWDATA    <= '0;
      bus.O_RSP_VALID <= 1'b0;
      bus.O_RSP_RDATA <= '0;
      bus.O_RSP_ERR   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.I_CMD_VALID) begin
            bus.O_PWRITE <= bus.I_CMD_WRITE;
            bus.O_PADDR  <= bus.I_CMD_ADDR;
            bus.O_PWDATA <= bus.I_CMD_WDATA;
            bus.O_PSEL   <= 1'b1;
            wait_q       <= '0;
            state_q      <= StSetup;
          end
        end
        StSetup: begin
          bus.O_PENABLE <= 1'b1;
          state_q       <= StAccess;
        end
        StAccess: begin
          if (bus.I_PREADY) begin
            bus.O_RSP_RDATA <= bus.O_PWRITE ? '0 : bus.I_PRDATA;
            bus.O_RSP_ERR   <= 1'b0;
            bus.O_RSP_VALID <= 1'b1;
            bus.O_PSEL      <= 1'b0;
            bus.O_PENABLE   <= 1'b0;
            state_q         <= StResp;
          end else if (wait_q == WaitLast) begin
            bus.O_RSP_RDATA <= '0;
            bus.O_RSP_ERR   <= 1'b1;
            bus.O_RSP_VALID <= 1'b1;
            bus.O_PSEL      <= 1'b0;
            bus.O_PENABLE   <= 1'b0;
            state_q         <= StResp;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        StResp: begin
          if (bus.I_RSP_READY) begin
            bus.O_RSP_VALID <= 1'b0;
            state_q         <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master (TIMEOUT = 4): table of transfers driven through a cycle-exact
// responder, expected responses queued at accept and compared at the response handshake.
module tb_apb_master;

  localparam int To = 4;

  logic clk;
  logic rst_n;
  apb_master_if bus ();

  apb_master #(.TIMEOUT(To)) dut (
    .I_PCLK    (clk),
    .I_PRESET_N(rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] prdata;
    int          rsp_delay;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after the response.
  task automatic run_txn(input vec_t v);
    int   n_acc;
    rsp_t exp;
    n_acc = (v.waits >= To) ? To : v.waits + 1;
    chk("idle_cmd_ready", 32'(bus.O_CMD_READY), 32'd1);
    bus.I_CMD_VALID = 1'b1;
    bus.I_CMD_WRITE = v.write;
    bus.I_CMD_ADDR  = v.addr;
    bus.I_CMD_WDATA = v.wdata;
    sb.push_back('{v.exp_rdata, v.exp_err});
    @(negedge clk);
    // Scramble command inputs so only the latched copy can reach the bus.
    bus.I_CMD_VALID = 1'b0;
    bus.I_CMD_WRITE = ~v.write;
    bus.I_CMD_ADDR  = 32'hFFFF_FFFF;
    bus.I_CMD_WDATA = 32'hFFFF_FFFF;
    bus.I_PREADY    = 1'b1;
    bus.I_PRDATA    = 32'hDEAD_BEEF;
    chk("setup_sel_en", 32'({bus.O_PSEL, bus.O_PENABLE}), 32'b10);
    chk("setup_paddr", bus.O_PADDR, v.addr);
    chk("setup_pwdata", bus.O_PWDATA, v.wdata);
    chk("setup_pwrite", 32'(bus.O_PWRITE), 32'(v.write));
    for (int i = 0; i < n_acc; i++) begin
      @(negedge clk);
      chk("access_sel_en", 32'({bus.O_PSEL, bus.O_PENABLE}), 32'b11);
      chk("access_paddr", bus.O_PADDR, v.addr);
      chk("access_pwdata", bus.O_PWDATA, v.wdata);
      bus.I_PREADY = (i >= v.waits);
      bus.I_PRDATA = (i >= v.waits) ? v.prdata : 32'hDEAD_BEEF;
    end
    @(negedge clk);
    bus.I_PREADY = 1'b1;
    bus.I_PRDATA = 32'hDEAD_BEEF;
    chk("resp_sel_en", 32'({bus.O_PSEL, bus.O_PENABLE}), 32'b00);
    chk("resp_valid", 32'(bus.O_RSP_VALID), 32'd1);
    chk("resp_paddr_held", bus.O_PADDR, v.addr);
    for (int k = 0; k < v.rsp_delay; k++) begin
      bus.I_RSP_READY = 1'b0;
      bus.I_CMD_VALID = 1'b1;
      bus.I_CMD_ADDR  = 32'h0000_0900;
      @(negedge clk);
      chk("bp_valid", 32'(bus.O_RSP_VALID), 32'd1);
      chk("bp_rdata", bus.O_RSP_RDATA, v.exp_rdata);
      chk("bp_err", 32'(bus.O_RSP_ERR), 32'(v.exp_err));
      chk("bp_cmd_ready", 32'(bus.O_CMD_READY), 32'd0);
      chk("bp_psel", 32'(bus.O_PSEL), 32'd0);
    end
    bus.I_CMD_VALID = 1'b0;
    bus.I_RSP_READY = 1'b1;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL sb_underflow: got response with no expected entry");
    end else begin
      exp = sb.pop_front();
      chk("rsp_rdata", bus.O_RSP_RDATA, exp.rdata);
      chk("rsp_err", 32'(bus.O_RSP_ERR), 32'(exp.err));
    end
    @(negedge clk);
    bus.I_RSP_READY = 1'b0;
    bus.I_PREADY    = 1'b0;
    chk("post_rsp_valid", 32'(bus.O_RSP_VALID), 32'd0);
    chk("post_cmd_ready", 32'(bus.O_CMD_READY), 32'd1);
    chk("post_psel", 32'(bus.O_PSEL), 32'd0);
  endtask

  vec_t vecs[7];

  initial begin
    //          wr    addr          wdata         waits prdata        dly  exp_rdata     err
    vecs[0] = '{1'b1, 32'h0000_0004, 32'hA5A5_5A5A, 0, 32'h1111_1111, 0, 32'h0000_0000, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_0008, 32'h0,         3, 32'h1234_5678, 0, 32'h1234_5678, 1'b0};
    vecs[2] = '{1'b0, 32'h0000_000C, 32'h0,         4, 32'h5555_5555, 0, 32'h0000_0000, 1'b1};
    vecs[3] = '{1'b0, 32'h0000_0010, 32'h0,         3, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 1'b0};
    vecs[4] = '{1'b0, 32'h0000_0014, 32'h0,         0, 32'h0BAD_C0DE, 5, 32'h0BAD_C0DE, 1'b0};
    vecs[5] = '{1'b1, 32'h0000_0018, 32'h7777_8888, 4, 32'h0,         2, 32'h0000_0000, 1'b1};
    vecs[6] = '{1'b1, 32'h0000_001C, 32'h0102_0304, 1, 32'hFFFF_FFFF, 0, 32'h0000_0000, 1'b0};

    rst_n           = 1'b0;
    bus.I_CMD_VALID = 1'b1;
    bus.I_CMD_WRITE = vecs[0].write;
    bus.I_CMD_ADDR  = vecs[0].addr;
    bus.I_CMD_WDATA = vecs[0].wdata;
    bus.I_RSP_READY = 1'b0;
    bus.I_PRDATA    = 32'h0;
    bus.I_PREADY    = 1'b0;

    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_psel", 32'(bus.O_PSEL), 32'd0);
      chk("rst_penable", 32'(bus.O_PENABLE), 32'd0);
      chk("rst_pwrite", 32'(bus.O_PWRITE), 32'd0);
      chk("rst_paddr", bus.O_PADDR, 32'd0);
      chk("rst_pwdata", bus.O_PWDATA, 32'd0);
      chk("rst_rsp_valid", 32'(bus.O_RSP_VALID), 32'd0);
      chk("rst_rsp_rdata", bus.O_RSP_RDATA, 32'd0);
      chk("rst_rsp_err", 32'(bus.O_RSP_ERR), 32'd0);
      chk("rst_cmd_ready", 32'(bus.O_CMD_READY), 32'd1);
    end
    rst_n = 1'b1;

    foreach (vecs[i]) run_txn(vecs[i]);

    // Reset during the second wait state: transfer vanishes without a response.
    bus.I_CMD_VALID = 1'b1;
    bus.I_CMD_WRITE = 1'b0;
    bus.I_CMD_ADDR  = 32'h0000_0020;
    bus.I_CMD_WDATA = 32'h0;
    @(negedge clk);
    bus.I_CMD_VALID = 1'b0;
    bus.I_PREADY    = 1'b0;
    chk("mid_setup", 32'({bus.O_PSEL, bus.O_PENABLE}), 32'b10);
    @(negedge clk);
    chk("mid_access1", 32'({bus.O_PSEL, bus.O_PENABLE}), 32'b11);
    @(negedge clk);
    chk("mid_access2", 32'({bus.O_PSEL, bus.O_PENABLE}), 32'b11);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.I_PREADY    = 1'b1;
    bus.I_RSP_READY = 1'b1;
    chk("mid_rst_sel_en", 32'({bus.O_PSEL, bus.O_PENABLE}), 32'b00);
    chk("mid_rst_cmd_ready", 32'(bus.O_CMD_READY), 32'd1);
    for (int c = 0; c < 4; c++) begin
      chk("mid_rst_no_rsp", 32'(bus.O_RSP_VALID), 32'd0);
      @(negedge clk);
    end
    bus.I_PREADY    = 1'b0;
    bus.I_RSP_READY = 1'b0;
    run_txn('{1'b0, 32'h0000_0024, 32'h0, 2, 32'h600D_600D, 1, 32'h600D_600D, 1'b0});

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
